alu_issue_regfile: RTL and testbench



---
 rtl/alu_issue_regfile_if.sv | 23 ++
 rtl/alu_issue_regfile.sv | 105 ++++++++++
 tb/tb_alu_issue_regfile.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_regfile_if.sv
// Instruction-in / result-out handshake bundle for alu_issue_regfile.
//   instr_valid/instr_ready/instr   : upstream instruction handshake
//   result_valid/result_ready       : downstream result handshake
//   result/result_flags             : captured Z and {illegal, overflow, equal, zero}
interface alu_issue_regfile_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic        result_valid;
   logic        result_ready;
   logic [31:0] result;
   logic [3:0]  result_flags;

   modport master (
      output instr_valid, instr, result_ready,
      input  instr_ready, result_valid, result, result_flags
   );

   modport slave (
      input  instr_valid, instr, result_ready,
      output instr_ready, result_valid, result, result_flags
   );
endinterface

// File: rtl/alu_issue_regfile.sv
// Issue/writeback stage around an external combinational 32-bit ALU.
// Accepts one instruction at a time, reads operands from a 32x32 register
// file, drives the ALU from registers, captures Z and flags one cycle later,
// writes Z back to rd and holds the result for a downstream handshake.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : instruction and result handshakes
//   alu_x/alu_y/alu_op: registered ALU operands and opcode
//   alu_z, alu_*flags : ALU result and flags, sampled at the end of EXEC
//   dbg_addr/dbg_data : combinational register-file read port (r0 reads 0)
module alu_issue_regfile (
   input  logic                clk,
   input  logic                rst,
   alu_issue_regfile_if.slave  bus,
   output logic [31:0]         alu_x,
   output logic [31:0]         alu_y,
   output logic [3:0]          alu_op,
   input  logic [31:0]         alu_z,
   input  logic                alu_overflow,
   input  logic                alu_equal,
   input  logic                alu_zero,
   input  logic [4:0]          dbg_addr,
   output logic [31:0]         dbg_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] regs [32];
   logic [4:0]  rd_q;
   logic        illegal;

   logic [3:0]  f_op;
   logic [4:0]  f_rd, f_rs, f_rt;
   logic        f_use_imm;
   logic [11:0] f_imm;

   assign f_op      = bus.instr[31:28];
   assign f_rd      = bus.instr[27:23];
   assign f_rs      = bus.instr[22:18];
   assign f_rt      = bus.instr[17:13];
   assign f_use_imm = bus.instr[12];
   assign f_imm     = bus.instr[11:0];

   // Reserved opcodes: 4 and 11..15.
   assign illegal = (alu_op == 4'd4) || (alu_op >= 4'd11);

   assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt        = state;
      bus.instr_ready  = 1'b0;
      bus.result_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.instr_ready = 1'b1;
            if (bus.instr_valid) state_nxt = EXEC;
         end
         EXEC: state_nxt = DONE;
         DONE: begin
            bus.result_valid = 1'b1;
            if (bus.result_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
         alu_x            <= '0;
         alu_y            <= '0;
         alu_op           <= '0;
         rd_q             <= '0;
         bus.result       <= '0;
         bus.result_flags <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.instr_valid) begin
                  alu_op <= f_op;
                  rd_q   <= f_rd;
                  alu_x  <= regs[f_rs];
                  alu_y  <= f_use_imm ? {{20{f_imm[11]}}, f_imm} : regs[f_rt];
               end
            end
            EXEC: begin
               bus.result       <= alu_z;
               bus.result_flags <= {illegal, alu_overflow, alu_equal, alu_zero};
               if ((rd_q != '0) && !illegal) regs[rd_q] <= alu_z;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_regfile.sv
module tb_alu_issue_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_x, alu_y, alu_z;
   logic [3:0]  alu_op;
   logic        alu_overflow, alu_equal, alu_zero;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   alu_issue_regfile_if bus ();

   alu_issue_regfile dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .alu_x        (alu_x),
      .alu_y        (alu_y),
      .alu_op       (alu_op),
      .alu_z        (alu_z),
      .alu_overflow (alu_overflow),
      .alu_equal    (alu_equal),
      .alu_zero     (alu_zero),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data)
   );

   always #5 clk = ~clk;

   // Stand-in ALU: 5 = add, 6 = sub, 0/1/2 = and/or/xor, reserved codes give 0 with no flags.
   always_comb begin
      alu_z        = alu_x;
      alu_overflow = 1'b0;
      alu_equal    = (alu_x == alu_y);
      alu_zero     = 1'b0;
      case (alu_op)
         4'd0: alu_z = alu_x & alu_y;
         4'd1: alu_z = alu_x | alu_y;
         4'd2: alu_z = alu_x ^ alu_y;
         4'd5: begin
            alu_z        = alu_x + alu_y;
            alu_overflow = (alu_x[31] == alu_y[31]) && (alu_z[31] != alu_x[31]);
         end
         4'd6: begin
            alu_z        = alu_x - alu_y;
            alu_overflow = (alu_x[31] != alu_y[31]) && (alu_z[31] != alu_x[31]);
         end
         4'd4, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: begin
            alu_z     = '0;
            alu_equal = 1'b0;
         end
         default: ;
      endcase
      if (!(alu_op == 4'd4 || alu_op >= 4'd11)) alu_zero = (alu_z == '0);
   end

   int errors = 0;
   int checks = 0;
   logic [35:0] sb [$];   // {flags, result}

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic u, input logic [11:0] imm);
      return {op, rd, rs, rt, u, imm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic dbg_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
      dbg_addr = a;
      #1;
      chk(name, dbg_data, exp);
   endtask

   // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
   task automatic send(input logic [31:0] w, output bit ok);
      ok = 0;
      bus.instr       = w;
      bus.instr_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (bus.instr_ready) begin
            @(posedge clk); #1;
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      bus.instr_valid = 1'b0;
      if (!ok) begin
         errors++;
         checks++;
         $display("FAIL accept_timeout: got no instr_ready expected ready within 50 cycles");
      end
   endtask

   task automatic wait_idle();
      bit seen = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.instr_ready) begin
            seen = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!seen) begin
         errors++;
         checks++;
         $display("FAIL idle_timeout: got instr_ready=0 expected 1 within 50 cycles");
      end
   endtask

   task automatic issue(input logic [31:0] w, input logic [31:0] res, input logic [3:0] fl);
      bit ok;
      sb.push_back({fl, res});
      send(w, ok);
      if (ok) begin
         chk("lat_exec_valid", {31'd0, bus.result_valid}, 32'd0);
         @(posedge clk); #1;
         chk("lat_done_valid", {31'd0, bus.result_valid}, 32'd1);
      end
      wait_idle();
   endtask

   // Scoreboard monitor: compares every accepted result against the queue head.
   initial begin
      logic [35:0] e;
      forever begin
         @(negedge clk);
         if (bus.result_valid && bus.result_ready) begin
            if (sb.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL unexpected_result: got 0x%08h expected no result", bus.result);
            end else begin
               e = sb.pop_front();
               chk("sb_result", bus.result, e[31:0]);
               chk("sb_flags", {28'd0, bus.result_flags}, {28'd0, e[35:32]});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      rst              = 1'b1;
      bus.instr_valid  = 1'b0;
      bus.instr        = '0;
      bus.result_ready = 1'b1;
      dbg_addr         = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_instr_ready", {31'd0, bus.instr_ready}, 32'd1);
      chk("rst_result_valid", {31'd0, bus.result_valid}, 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_flags", {28'd0, bus.result_flags}, 32'd0);
      for (int i = 0; i < 32; i++) dbg_chk("rst_reg", 5'(i), 32'd0);
      @(posedge clk); #1;

      // Immediate loads with sign extension.
      issue(mk(4'd5, 5'd1, 5'd0, 5'd0, 1'b1, 12'h7FF), 32'h0000_07FF, 4'b0000);
      dbg_chk("r1", 5'd1, 32'h0000_07FF);
      issue(mk(4'd5, 5'd2, 5'd0, 5'd0, 1'b1, 12'h800), 32'hFFFF_F800, 4'b0000);
      dbg_chk("r2", 5'd2, 32'hFFFF_F800);

      // Register ops and back-to-back read-after-write.
      issue(mk(4'd6, 5'd3, 5'd1, 5'd1, 1'b0, 12'h000), 32'h0000_0000, 4'b0011);
      issue(mk(4'd5, 5'd4, 5'd1, 5'd2, 1'b0, 12'h000), 32'hFFFF_FFFF, 4'b0000);
      issue(mk(4'd5, 5'd5, 5'd4, 5'd0, 1'b1, 12'h002), 32'h0000_0001, 4'b0000);
      dbg_chk("r4", 5'd4, 32'hFFFF_FFFF);
      dbg_chk("r5", 5'd5, 32'h0000_0001);

      // r0 destination and reserved opcode.
      issue(mk(4'd5, 5'd0, 5'd0, 5'd0, 1'b1, 12'h005), 32'h0000_0005, 4'b0000);
      dbg_chk("r0", 5'd0, 32'd0);
      issue(mk(4'd5, 5'd6, 5'd0, 5'd0, 1'b1, 12'h123), 32'h0000_0123, 4'b0000);
      issue(mk(4'd4, 5'd6, 5'd1, 5'd2, 1'b0, 12'h000), 32'h0000_0000, 4'b1000);
      dbg_chk("r6_kept", 5'd6, 32'h0000_0123);
      @(posedge clk); #1;

      // Backpressure: result held for 5 DONE cycles, stray instr_valid ignored.
      bus.result_ready = 1'b0;
      sb.push_back({4'b0000, 32'h0000_0800});
      send(mk(4'd5, 5'd9, 5'd1, 5'd0, 1'b1, 12'h001), ok);
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", {31'd0, bus.result_valid}, 32'd1);
         chk("bp_result", bus.result, 32'h0000_0800);
         chk("bp_flags", {28'd0, bus.result_flags}, 32'd0);
         chk("bp_instr_ready", {31'd0, bus.instr_ready}, 32'd0);
         bus.instr       = mk(4'd5, 5'd10, 5'd0, 5'd0, 1'b1, 12'h055);
         bus.instr_valid = (c == 2);
         @(posedge clk); #1;
      end
      bus.instr_valid  = 1'b0;
      bus.result_ready = 1'b1;
      wait_idle();
      @(posedge clk); #1;
      chk("bp_stray_no_exec", {31'd0, bus.result_valid}, 32'd0);
      dbg_chk("r9", 5'd9, 32'h0000_0800);
      dbg_chk("r10_untouched", 5'd10, 32'd0);
      @(posedge clk); #1;

      // Reset during EXEC drops the instruction and clears the file.
      send(mk(4'd5, 5'd7, 5'd1, 5'd0, 1'b1, 12'h001), ok);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_exec_ready", {31'd0, bus.instr_ready}, 32'd1);
      chk("rst_exec_valid", {31'd0, bus.result_valid}, 32'd0);
      dbg_chk("r7_dropped", 5'd7, 32'd0);
      dbg_chk("r1_cleared", 5'd1, 32'd0);
      repeat (3) @(posedge clk);
      #1;

      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
